// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port among mem, fpu and alu producers.
// Fixed priority mem > fpu > alu with starvation promotion; the winning write is registered.
module wb_arbiter #(
    parameter int unsigned DW           = 32,
    parameter int unsigned RW           = 7,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          mem_valid,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,

    input  logic          fpu_valid,
    input  logic [RW-1:0] fpu_rd,
    input  logic [DW-1:0] fpu_data,
    output logic          fpu_ready,

    input  logic          alu_valid,
    input  logic [RW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,

    output logic          wb_we,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          wb_stall
);

    localparam int unsigned    CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);
    // Top bit of the rd tag marks a real register write.
    localparam int unsigned    VB    = RW - 1;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_FPU,
        SRC_ALU
    } src_e;

    logic [CW-1:0] mem_wait;
    logic [CW-1:0] fpu_wait;
    logic [CW-1:0] alu_wait;

    logic          mem_cand;
    logic          fpu_cand;
    logic          alu_cand;
    logic          mem_starved;
    logic          fpu_starved;
    logic          alu_starved;

    src_e          win;
    logic [RW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    assign mem_cand    = mem_valid & mem_rd[VB];
    assign fpu_cand    = fpu_valid & fpu_rd[VB];
    assign alu_cand    = alu_valid & alu_rd[VB];

    assign mem_starved = mem_cand & (mem_wait == LIMIT);
    assign fpu_starved = fpu_cand & (fpu_wait == LIMIT);
    assign alu_starved = alu_cand & (alu_wait == LIMIT);

    // Starved candidates outrank everyone; within each tier the order is mem, fpu, alu.
    always_comb begin
        win = SRC_NONE;
        if (mem_starved)      win = SRC_MEM;
        else if (fpu_starved) win = SRC_FPU;
        else if (alu_starved) win = SRC_ALU;
        else if (mem_cand)    win = SRC_MEM;
        else if (fpu_cand)    win = SRC_FPU;
        else if (alu_cand)    win = SRC_ALU;
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (win)
            SRC_MEM: begin
                sel_rd   = mem_rd;
                sel_data = mem_data;
            end
            SRC_FPU: begin
                sel_rd   = fpu_rd;
                sel_data = fpu_data;
            end
            SRC_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    // Null-tag requests are acknowledged immediately without taking the port.
    assign mem_ready = rst & ((win == SRC_MEM) | (mem_valid & ~mem_rd[VB]));
    assign fpu_ready = rst & ((win == SRC_FPU) | (fpu_valid & ~fpu_rd[VB]));
    assign alu_ready = rst & ((win == SRC_ALU) | (alu_valid & ~alu_rd[VB]));
    assign wb_stall  = rst & alu_valid & ~alu_ready;

    function automatic logic [CW-1:0] next_wait(
        input logic          valid,
        input logic          cand,
        input logic          granted,
        input logic [CW-1:0] cnt
    );
        if (!valid || granted) return '0;
        if (cand && (cnt != LIMIT)) return cnt + CW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            mem_wait <= '0;
            fpu_wait <= '0;
            alu_wait <= '0;
        end else begin
            wb_we <= (win != SRC_NONE);
            if (win != SRC_NONE) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
            mem_wait <= next_wait(mem_valid, mem_cand, win == SRC_MEM, mem_wait);
            fpu_wait <= next_wait(fpu_valid, fpu_cand, win == SRC_FPU, fpu_wait);
            alu_wait <= next_wait(alu_valid, alu_cand, win == SRC_ALU, alu_wait);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of the arbitration rules.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int RW = 7;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, fpu_valid, alu_valid;
    logic [RW-1:0] mem_rd, fpu_rd, alu_rd;
    logic [DW-1:0] mem_data, fpu_data, alu_data;
    logic          mem_ready, fpu_ready, alu_ready;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DW(DW),
        .RW(RW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_valid(mem_valid),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .fpu_valid(fpu_valid),
        .fpu_rd(fpu_rd),
        .fpu_data(fpu_data),
        .fpu_ready(fpu_ready),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .wb_we(wb_we),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .wb_stall(wb_stall)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        fpu_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drive_all();
        mem_valid = 1'b1; mem_rd = 7'h41; mem_data = 32'h1111_0001;
        fpu_valid = 1'b1; fpu_rd = 7'h42; fpu_data = 32'h2222_0002;
        alu_valid = 1'b1; alu_rd = 7'h43; alu_data = 32'h3333_0003;
    endtask

    task automatic test_reset();
        logic [2:0] rdy;
        rst = 1'b0;
        drive_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rdy = {alu_ready, fpu_ready, mem_ready};
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", wb_we); end
        checks++; if (wb_rd !== 7'h00) begin errors++; $display("FAIL reset_rd got=%h exp=00", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", wb_data); end
        checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", rdy); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", wb_stall); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        rdy = {alu_ready, fpu_ready, mem_ready};
        checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL release_ready got=%b exp=001", rdy); end
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL release_stall got=%b exp=1", wb_stall); end
        next_cycle();
        idle();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 7'h41 || wb_data !== 32'h1111_0001) begin
            errors++; $display("FAIL release_wb got we=%b rd=%h data=%h exp we=1 rd=41 data=11110001", wb_we, wb_rd, wb_data);
        end
    endtask

    task automatic test_single_alu();
        idle();
        next_cycle();
        alu_valid = 1'b1; alu_rd = 7'h45; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", wb_stall); end
        next_cycle();
        idle();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 7'h45 || wb_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL alu_wb got we=%b rd=%h data=%h exp we=1 rd=45 data=deadbeef", wb_we, wb_rd, wb_data);
        end
        next_cycle();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL alu_we_drop got=%b exp=0", wb_we); end
        checks++; if (wb_rd !== 7'h45) begin errors++; $display("FAIL alu_rd_hold got=%h exp=45", wb_rd); end
    endtask

    task automatic test_starvation();
        int            exp_src [7] = '{0, 0, 0, 0, 1, 2, 0};
        logic [RW-1:0] tag     [3] = '{7'h41, 7'h42, 7'h43};
        logic [2:0]    rdy;
        idle();
        next_cycle();
        drive_all();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rdy = {alu_ready, fpu_ready, mem_ready};
            checks++; if (rdy !== (3'b001 << exp_src[k])) begin
                errors++; $display("FAIL starve_ready[%0d] got=%b exp=%b", k, rdy, 3'b001 << exp_src[k]);
            end
            checks++; if (wb_stall !== (exp_src[k] != 2)) begin
                errors++; $display("FAIL starve_stall[%0d] got=%b exp=%b", k, wb_stall, exp_src[k] != 2);
            end
            next_cycle();
            checks++; if (wb_we !== 1'b1 || wb_rd !== tag[exp_src[k]]) begin
                errors++; $display("FAIL starve_wb[%0d] got we=%b rd=%h exp we=1 rd=%h", k, wb_we, wb_rd, tag[exp_src[k]]);
            end
        end
        idle();
    endtask

    task automatic test_null_tag();
        idle();
        next_cycle();
        mem_valid = 1'b1; mem_rd = 7'h41; mem_data = 32'hA5A5_0041;
        fpu_valid = 1'b1; fpu_rd = 7'h22; fpu_data = 32'h5A5A_0022;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b1 || fpu_ready !== 1'b1) begin
            errors++; $display("FAIL null_ready got mem=%b fpu=%b exp mem=1 fpu=1", mem_ready, fpu_ready);
        end
        next_cycle();
        idle();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 7'h41 || wb_data !== 32'hA5A5_0041) begin
            errors++; $display("FAIL null_wb got we=%b rd=%h data=%h exp we=1 rd=41 data=a5a50041", wb_we, wb_rd, wb_data);
        end
        next_cycle();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL null_single_write got=%b exp=0", wb_we); end
    endtask

    task automatic test_stall();
        idle();
        next_cycle();
        mem_valid = 1'b1; mem_rd = 7'h4C; mem_data = 32'h0BAD_F00D;
        alu_valid = 1'b1; alu_rd = 7'h47; alu_data = 32'h1234_5678;
        @(negedge clk);
        checks++; if (wb_stall !== 1'b1 || alu_ready !== 1'b0) begin
            errors++; $display("FAIL stall_c1 got stall=%b alu_ready=%b exp stall=1 alu_ready=0", wb_stall, alu_ready);
        end
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (wb_stall !== 1'b0 || alu_ready !== 1'b1) begin
            errors++; $display("FAIL stall_c2 got stall=%b alu_ready=%b exp stall=0 alu_ready=1", wb_stall, alu_ready);
        end
        checks++; if (wb_rd !== 7'h4C) begin errors++; $display("FAIL stall_c2_rd got=%h exp=4c", wb_rd); end
        next_cycle();
        idle();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 7'h47) begin
            errors++; $display("FAIL stall_c3_wb got we=%b rd=%h exp we=1 rd=47", wb_we, wb_rd);
        end
    endtask

    task automatic test_async_reset();
        int            exp_src [7] = '{0, 0, 0, 0, 1, 2, 0};
        logic [RW-1:0] tag     [3] = '{7'h41, 7'h42, 7'h43};
        logic [2:0]    rdy;
        idle();
        next_cycle();
        drive_all();
        next_cycle();
        checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL arst_pre_we got=%b exp=1", wb_we); end
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        rdy = {alu_ready, fpu_ready, mem_ready};
        checks++; if (wb_we !== 1'b0 || wb_rd !== 7'h00 || wb_data !== 32'h0) begin
            errors++; $display("FAIL arst_wb got we=%b rd=%h data=%h exp we=0 rd=00 data=0", wb_we, wb_rd, wb_data);
        end
        checks++; if (rdy !== 3'b000 || wb_stall !== 1'b0) begin
            errors++; $display("FAIL arst_ready got rdy=%b stall=%b exp rdy=000 stall=0", rdy, wb_stall);
        end
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rdy = {alu_ready, fpu_ready, mem_ready};
            checks++; if (rdy !== (3'b001 << exp_src[k])) begin
                errors++; $display("FAIL arst_rot_ready[%0d] got=%b exp=%b", k, rdy, 3'b001 << exp_src[k]);
            end
            next_cycle();
            checks++; if (wb_we !== 1'b1 || wb_rd !== tag[exp_src[k]]) begin
                errors++; $display("FAIL arst_rot_wb[%0d] got we=%b rd=%h exp we=1 rd=%h", k, wb_we, wb_rd, tag[exp_src[k]]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        bit            v    [3];
        bit            acc  [3];
        logic [RW-1:0] rd   [3];
        logic [DW-1:0] dat  [3];
        int            wcnt [3];
        int            win;
        bit            known;
        bit            exp_we;
        logic [RW-1:0] exp_rd;
        logic [DW-1:0] exp_data;
        logic [2:0]    rdy;
        logic [2:0]    exp_rdy;
        idle();
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            v[i] = 0; acc[i] = 0; wcnt[i] = 0;
            rd[i] = '0; dat[i] = '0;
        end
        known = 0;
        exp_rd = '0;
        exp_data = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i]          = ($urandom_range(0, 99) < 65);
                    rd[i]         = RW'($urandom);
                    rd[i][RW-1]   = ($urandom_range(0, 99) < 85);
                    dat[i]        = $urandom;
                end
            end
            mem_valid = v[0]; mem_rd = rd[0]; mem_data = dat[0];
            fpu_valid = v[1]; fpu_rd = rd[1]; fpu_data = dat[1];
            alu_valid = v[2]; alu_rd = rd[2]; alu_data = dat[2];

            win = -1;
            for (int i = 0; i < 3; i++)
                if (win < 0 && v[i] && rd[i][RW-1] && wcnt[i] == SL) win = i;
            for (int i = 0; i < 3; i++)
                if (win < 0 && v[i] && rd[i][RW-1]) win = i;
            for (int i = 0; i < 3; i++)
                acc[i] = (i == win) || (v[i] && !rd[i][RW-1]);

            @(negedge clk);
            rdy     = {alu_ready, fpu_ready, mem_ready};
            exp_rdy = {acc[2], acc[1], acc[0]};
            checks++; if (rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, rdy, exp_rdy);
            end
            checks++; if (wb_stall !== (v[2] && !acc[2])) begin
                errors++; $display("FAIL rand_stall[%0d] got=%b exp=%b", n, wb_stall, v[2] && !acc[2]);
            end

            for (int i = 0; i < 3; i++) begin
                if (!v[i] || i == win) wcnt[i] = 0;
                else if (rd[i][RW-1]) wcnt[i] = (wcnt[i] + 1 > SL) ? SL : wcnt[i] + 1;
            end
            exp_we = (win >= 0);
            if (exp_we) begin
                exp_rd   = rd[win];
                exp_data = dat[win];
                known    = 1;
            end

            next_cycle();
            checks++; if (wb_we !== exp_we) begin
                errors++; $display("FAIL rand_we[%0d] got=%b exp=%b", n, wb_we, exp_we);
            end
            if (known) begin
                checks++; if (wb_rd !== exp_rd || wb_data !== exp_data) begin
                    errors++; $display("FAIL rand_wb[%0d] got rd=%h data=%h exp rd=%h data=%h", n, wb_rd, wb_data, exp_rd, exp_data);
                end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        mem_rd = '0; fpu_rd = '0; alu_rd = '0;
        mem_data = '0; fpu_data = '0; alu_data = '0;
        test_reset();
        test_single_alu();
        test_starvation();
        test_null_tag();
        test_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
